// File: rtl/power_seq_pkg.sv
// Shared types, event codes and helpers for the target power sequencer.
package power_seq_pkg;

  typedef enum logic [1:0] {StOff, StFilter, StHoldoff, StRun} state_e;

  localparam logic [1:0] EvForced = 2'd0;
  localparam logic [1:0] EvUp     = 2'd1;
  localparam logic [1:0] EvDown   = 2'd2;
  localparam logic [1:0] EvGlitch = 2'd3;

  function automatic logic [7:0] pack_event(input logic [3:0] ch, input logic [1:0] code);
    return {ch, 2'b00, code};
  endfunction

  // Width of a counter that only needs to reach max(a, b) - 1.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/power_seq_channel.sv
// One target channel: power-sense synchroniser, glitch filter, hold-off and reset release.
module power_seq_channel
  import power_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_CYCLES  = 16,
  parameter int unsigned HOLDOFF_CYCLES = 131072
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       power_in,
  input  logic       force_reset,
  output logic       tgt_reset,
  output logic       tgt_ready,
  output logic [3:0] events
);

  localparam int unsigned CntW = cnt_width(FILTER_CYCLES, HOLDOFF_CYCLES);
  localparam logic [CntW-1:0] FiltLast = CntW'(FILTER_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLDOFF_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwr_s;
  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  assign pwr_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      state_q   <= StOff;
      cnt_q     <= '0;
      tgt_reset <= 1'b1;
      tgt_ready <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], power_in};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_reset <= (state_d != StRun);
      tgt_ready <= (state_d == StRun);
    end
  end

  // Power loss is checked before force so a coincident drop is reported as power loss.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    events  = '0;
    unique case (state_q)
      StOff: begin
        if (pwr_s && !force_reset) begin
          state_d = StFilter;
          cnt_d   = '0;
        end
      end
      StFilter: begin
        if (!pwr_s) begin
          state_d          = StOff;
          events[EvGlitch] = 1'b1;
        end else if (force_reset) begin
          state_d = StOff;
        end else if (cnt_q == FiltLast) begin
          state_d = StHoldoff;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StHoldoff: begin
        if (!pwr_s) begin
          state_d          = StOff;
          events[EvGlitch] = 1'b1;
        end else if (force_reset) begin
          state_d = StOff;
        end else if (cnt_q == HoldLast) begin
          state_d      = StRun;
          events[EvUp] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!pwr_s) begin
          state_d        = StOff;
          events[EvDown] = 1'b1;
        end else if (force_reset) begin
          state_d          = StOff;
          events[EvForced] = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/target_power_seq.sv
// Multi-channel target power sequencer with a pending-bit event arbiter feeding the log path.
module target_power_seq
  import power_seq_pkg::*;
#(
  parameter int unsigned CHANNELS       = 1,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_CYCLES  = 16,
  parameter int unsigned HOLDOFF_CYCLES = 131072
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] power_in,
  input  logic [CHANNELS-1:0] force_reset,
  output logic [CHANNELS-1:0] tgt_reset,
  output logic [CHANNELS-1:0] tgt_ready,
  output logic                event_strobe,
  output logic [7:0]          event_val,
  output logic                event_overflow
);

  localparam int unsigned NumEv = CHANNELS * 4;

  logic [NumEv-1:0] ev_set, pending_q, pending_d, grant;
  logic             found;
  logic [3:0]       sel_ch;
  logic [1:0]       sel_code;
  logic             ovf_d;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    power_seq_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .FILTER_CYCLES (FILTER_CYCLES),
      .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .power_in   (power_in[g]),
      .force_reset(force_reset[g]),
      .tgt_reset  (tgt_reset[g]),
      .tgt_ready  (tgt_ready[g]),
      .events     (ev_set[g*4 +: 4])
    );
  end

  // Bit index is channel*4 + code, so a low-to-high scan gives channel then code priority.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    sel_ch   = '0;
    sel_code = '0;
    for (int i = 0; i < NumEv; i++) begin
      if (!found && pending_q[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        sel_ch   = 4'(i / 4);
        sel_code = 2'(i % 4);
      end
    end
    // A set landing on the bit being granted this cycle keeps it pending without loss.
    pending_d = (pending_q & ~grant) | ev_set;
    ovf_d     = event_overflow | (|(ev_set & pending_q & ~grant));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q      <= '0;
      event_strobe   <= 1'b0;
      event_val      <= '0;
      event_overflow <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      event_strobe   <= found;
      event_val      <= found ? pack_event(sel_ch, sel_code) : 8'h00;
      event_overflow <= ovf_d;
    end
  end

endmodule
